debug_bram_responder: RTL and testbench

Dual-port 32-bit word memory that answers the CPU debug memory port (A2/WD2/WE2/RD2) while serving the core on a second port (A1/WD1/WE1/RD1). One instance backs instruction RAM and one backs data RAM inside RV32Core. The debug port is the load/dump path driven by the simulation bench and by future hardware loaders. An optional clear sequencer zeroes the array after reset.

---
 rtl/debug_bram_pkg.sv | 19 +
 rtl/bram_clear_seq.sv | 51 +++++
 rtl/debug_bram_responder.sv | 93 +++++++++
 tb/tb_debug_bram_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/debug_bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debug_bram_pkg
// Description : Shared constants and clear-FSM state type for debug_bram_responder.
// Revision    : 1.0 - initial release
// ============================================================================
package debug_bram_pkg;

    localparam int WORDS_DEFAULT = 4096;
    localparam int IDX_W         = $clog2(WORDS_DEFAULT);
    localparam int LANES         = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage
`default_nettype wire

// File: rtl/bram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : bram_clear_seq
// Description : Post-reset sequencer that zeroes every word of the array,
//               one word per cycle (used only with BRAM_CLEAR_ON_RESET_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module bram_clear_seq
    import debug_bram_pkg::*;
#(
    parameter int WORDS = WORDS_DEFAULT,
    localparam int IW   = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          clear_we_o,
    output logic [IW-1:0] clear_idx_o,
    output logic          busy_o
);

    clr_state_e    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // No clear write happens on an edge where reset is still asserted.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clear_we_o  = 1'b0;
        clear_idx_o = cnt_q;
        busy_o      = (state_q == CLEAR);
        if (state_q == CLEAR) begin
            clear_we_o = !rst_i;
            cnt_d      = cnt_q + IW'(1);
            if (cnt_q == IW'(WORDS - 1)) begin
                state_d = IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/debug_bram_responder.sv
`default_nettype none
// ============================================================================
// Module      : debug_bram_responder
// Description : Dual-port 32-bit word memory; port 1 serves the core, port 2
//               the debug load/dump path. Optional post-reset clear is enabled
//               by defining BRAM_CLEAR_ON_RESET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_bram_responder
    import debug_bram_pkg::*;
#(
    parameter int WORDS = WORDS_DEFAULT
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [31:0] A1,
    input  logic [31:0] WD1,
    input  logic [3:0]  WE1,
    output logic [31:0] RD1,
    input  logic [31:0] A2,
    input  logic [31:0] WD2,
    input  logic [3:0]  WE2,
    output logic [31:0] RD2,
    output logic        Busy
);

    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem_q [WORDS];
    logic [31:0]   rd1_q, rd2_q;
    logic [AW-1:0] idx1, idx2;
    logic          port_en;
    logic          clr_we;
    logic [AW-1:0] clr_idx;
    logic          busy;
    logic          unused_addr_bits;

    // Upper address bits are ignored so out-of-range addresses alias.
    assign idx1 = A1[AW+1:2];
    assign idx2 = A2[AW+1:2];
    assign unused_addr_bits = ^{A1[31:AW+2], A1[1:0], A2[31:AW+2], A2[1:0]};

`ifdef BRAM_CLEAR_ON_RESET_EN
    bram_clear_seq #(
        .WORDS (WORDS)
    ) u_clear_seq (
        .clk_i       (CPU_CLK),
        .rst_i       (CPU_RST),
        .clear_we_o  (clr_we),
        .clear_idx_o (clr_idx),
        .busy_o      (busy)
    );
`else
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
    assign busy    = 1'b0;
`endif

    assign port_en = !CPU_RST && !busy;

    // Port 2 lanes are applied last so the debug port wins a same-word collision.
    always_ff @(posedge CPU_CLK) begin
        if (clr_we) begin
            mem_q[clr_idx] <= '0;
        end
        for (int i = 0; i < LANES; i++) begin
            if (port_en && WE1[i]) begin
                mem_q[idx1][8*i +: 8] <= WD1[8*i +: 8];
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (port_en && WE2[i]) begin
                mem_q[idx2][8*i +: 8] <= WD2[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST || busy) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            rd1_q <= mem_q[idx1];
            rd2_q <= mem_q[idx2];
        end
    end

    assign RD1  = rd1_q;
    assign RD2  = rd2_q;
    assign Busy = busy;

endmodule
`default_nettype wire

// File: tb/tb_debug_bram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_bram_responder
// Description : Directed self-checking bench for debug_bram_responder; covers
//               both builds of BRAM_CLEAR_ON_RESET_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_bram_responder;

    logic        CPU_CLK = 1'b0;
    logic        CPU_RST;
    logic [31:0] A1, WD1, A2, WD2;
    logic [3:0]  WE1, WE2;
    logic [31:0] RD1, RD2;
    logic        Busy;

    int passed = 0;
    int total  = 0;

    debug_bram_responder #(.WORDS(4096)) dut (
        .CPU_CLK (CPU_CLK),
        .CPU_RST (CPU_RST),
        .A1      (A1),
        .WD1     (WD1),
        .WE1     (WE1),
        .RD1     (RD1),
        .A2      (A2),
        .WD2     (WD2),
        .WE2     (WE2),
        .RD2     (RD2),
        .Busy    (Busy)
    );

    always #5 CPU_CLK = ~CPU_CLK;

    task automatic step();
        @(posedge CPU_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        A1 = a; WD1 = d; WE1 = we;
        step();
        WE1 = 4'b0000;
    endtask

    task automatic wr2(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        A2 = a; WD2 = d; WE2 = we;
        step();
        WE2 = 4'b0000;
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (Busy !== 1'b0 && n < 5000) begin
            step();
            n++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int nz;
        CPU_RST = 1'b1;
        A1 = '0; WD1 = '0; WE1 = '0;
        A2 = '0; WD2 = '0; WE2 = '0;
        repeat (3) step();
        chk("reset_rd1", RD1, 32'h0);
        chk("reset_rd2", RD2, 32'h0);

`ifdef BRAM_CLEAR_ON_RESET_EN
        chk("reset_busy", {31'b0, Busy}, 32'h1);
        repeat (10) step();
        chk("reset_hold_busy", {31'b0, Busy}, 32'h1);
        CPU_RST = 1'b0;
        wait_busy_low(n);
        chk("clear_edges", n, 32'd4096);
        nz = 0;
        for (int w = 0; w < 4096; w++) begin
            A2 = 32'(w) << 2;
            step();
            if (RD2 !== 32'h0) nz++;
        end
        chk("clear_all_zero", nz, 32'd0);
`else
        chk("reset_busy", {31'b0, Busy}, 32'h0);
        CPU_RST = 1'b0;
`endif

        // Debug write, core read
        wr2(32'h10, 32'hDEADBEEF, 4'b1111);
        A1 = 32'h10; step();
        chk("p2w_p1r", RD1, 32'hDEADBEEF);

        // Byte-lane merge
        wr1(32'h14, 32'h11223344, 4'b1111);
        wr2(32'h14, 32'hAAAAAAAA, 4'b0010);
        A1 = 32'h14; step();
        chk("lane_merge", RD1, 32'h1122AA44);

        // WE=0 is a pure read
        A2 = 32'h14; WD2 = 32'hFFFFFFFF; WE2 = 4'b0000; step();
        chk("pure_read_rd2", RD2, 32'h1122AA44);
        step();
        chk("pure_read_again", RD1, 32'h1122AA44);

        // Same-word collision, port 2 wins on overlapping lanes
        wr1(32'h1C, 32'h55667788, 4'b1111);
        A1 = 32'h1C; WD1 = 32'h01010101; WE1 = 4'b1111;
        A2 = 32'h1C; WD2 = 32'hFFFFFFFF; WE2 = 4'b0011;
        step();
        chk("coll_rd1_old", RD1, 32'h55667788);
        chk("coll_rd2_old", RD2, 32'h55667788);
        WE1 = 4'b0000; WE2 = 4'b0000;
        step();
        chk("coll_result", RD1, 32'h0101FFFF);

        // Address wrap and aliasing
        wr1(32'h3FFC, 32'hCAFEF00D, 4'b1111);
        wr1(32'h0, 32'h0BADF00D, 4'b1111);
        A2 = 32'hFFFFFFFC; step();
        chk("wrap_top", RD2, 32'hCAFEF00D);
        A2 = A2 + 32'd4; step();
        chk("wrap_zero", RD2, 32'h0BADF00D);
        A1 = 32'h4010; step();
        chk("alias_hi", RD1, 32'hDEADBEEF);

        // Cross-port read during write returns old value
        wr2(32'h24, 32'h87654321, 4'b1111);
        A1 = 32'h24; WD1 = 32'h12345678; WE1 = 4'b1111;
        A2 = 32'h24; step();
        WE1 = 4'b0000;
        chk("xport_old", RD2, 32'h87654321);
        step();
        chk("xport_new", RD2, 32'h12345678);

        // Both ports writing different words in the same cycle
        A1 = 32'h28; WD1 = 32'hA1A1A1A1; WE1 = 4'b1111;
        A2 = 32'h2C; WD2 = 32'hB2B2B2B2; WE2 = 4'b1111;
        step();
        WE1 = 4'b0000; WE2 = 4'b0000;
        A1 = 32'h2C; A2 = 32'h28; step();
        chk("dual_w_rd1", RD1, 32'hB2B2B2B2);
        chk("dual_w_rd2", RD2, 32'hA1A1A1A1);

`ifdef BRAM_CLEAR_ON_RESET_EN
        // Reset mid-clear restarts at word 0
        CPU_RST = 1'b1; step();
        CPU_RST = 1'b0;
        repeat (1000) step();
        CPU_RST = 1'b1; step();
        chk("midclr_busy", {31'b0, Busy}, 32'h1);
        chk("midclr_rd1", RD1, 32'h0);
        CPU_RST = 1'b0;
        wait_busy_low(n);
        chk("midclr_edges", n, 32'd4096);
        A1 = 32'h10; A2 = 32'h1C; step();
        chk("cleared_w4", RD1, 32'h0);
        chk("cleared_w7", RD2, 32'h0);
        A1 = 32'h3FFC; step();
        chk("cleared_w4095", RD1, 32'h0);
`else
        // Contents survive reset without the clear sequencer
        A1 = 32'h10; A2 = 32'h1C;
        CPU_RST = 1'b1;
        WD1 = 32'h99999999; WE1 = 4'b1111;
        repeat (2) step();
        WE1 = 4'b0000;
        chk("rst2_rd1", RD1, 32'h0);
        chk("rst2_rd2", RD2, 32'h0);
        chk("rst2_busy", {31'b0, Busy}, 32'h0);
        CPU_RST = 1'b0;
        step();
        chk("persist_w4", RD1, 32'hDEADBEEF);
        chk("persist_w7", RD2, 32'h0101FFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
